lsu: RTL and testbench

Multicycle load/store unit for the OTTER core's memory stage. It sits directly downstream of the ALU: the ALU's ADD result, rs1 + imm, is the effective address. The unit takes that address plus rs2 store data from the control FSM, runs one handshaked data-memory transaction, and returns aligned, sign- or zero-extended load data to the writeback mux. It detects misalignment, illegal size encodings and bus timeouts.

---
 rtl/lsu.sv | 164 ++++++++++++++++
 tb/tb_lsu.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// lsu: multicycle load/store unit for the OTTER memory stage.
// One handshaked bus transaction per request, with misalign/illegal/timeout detection.
module lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [7:0] TMAX = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic        st_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [7:0]  cnt;
    logic        illegal, misal, accept, tmo, to_done, cap;
    logic [1:0]  err_set;
    logic [3:0]  be_d;
    logic [31:0] wd_d, shifted, ext;

    assign accept = (state == IDLE) && start;
    assign tmo    = (TIMEOUT != 0) && (cnt == TMAX);

    always_comb begin
        illegal = 1'b1;
        unique case (funct3)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = is_store;
            default:                illegal = 1'b1;
        endcase
    end

    always_comb begin
        misal = 1'b0;
        be_d  = 4'b1111;
        wd_d  = wdata;
        unique case (funct3[1:0])
            2'b00: begin
                be_d = 4'b0001 << addr[1:0];
                wd_d = {4{wdata[7:0]}};
            end
            2'b01: begin
                misal = addr[0];
                be_d  = 4'b0011 << addr[1:0];
                wd_d  = {2{wdata[15:0]}};
            end
            2'b10: misal = |addr[1:0];
            default: misal = 1'b0;
        endcase
    end

    assign shifted = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        unique case (f3_q)
            3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  ext = {24'd0, shifted[7:0]};
            3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  ext = {16'd0, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    always_comb begin
        state_nxt = state;
        err_set   = 2'b00;
        to_done   = 1'b0;
        cap       = 1'b0;
        unique case (state)
            IDLE: if (start) begin
                if (illegal) begin
                    state_nxt = DONE;
                    err_set   = 2'b10;
                    to_done   = 1'b1;
                end else if (misal) begin
                    state_nxt = DONE;
                    err_set   = 2'b01;
                    to_done   = 1'b1;
                end else begin
                    state_nxt = REQ;
                end
            end
            REQ: if (mem_gnt) begin
                state_nxt = st_q ? DONE : WAIT;
                to_done   = st_q;
            end else if (tmo) begin
                state_nxt = DONE;
                err_set   = 2'b11;
                to_done   = 1'b1;
            end
            WAIT: if (mem_rvalid) begin
                state_nxt = DONE;
                to_done   = 1'b1;
                cap       = 1'b1;
            end else if (tmo) begin
                state_nxt = DONE;
                err_set   = 2'b11;
                to_done   = 1'b1;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign mem_req = (state == REQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            st_q      <= 1'b0;
            f3_q      <= 3'd0;
            off_q     <= 2'd0;
            cnt       <= 8'd0;
            err       <= 2'b00;
            rdata     <= 32'd0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_be    <= 4'd0;
            mem_wdata <= 32'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                st_q  <= is_store;
                f3_q  <= funct3;
                off_q <= addr[1:0];
                cnt   <= 8'd0;
            end else if (state == REQ || state == WAIT) begin
                cnt <= cnt + 8'd1;
            end
            // Bus fields only move when a real transaction is launched.
            if (accept && state_nxt == REQ) begin
                mem_we    <= is_store;
                mem_addr  <= {addr[31:2], 2'b00};
                mem_be    <= be_d;
                mem_wdata <= wd_d;
            end
            if (to_done) err <= err_set;
            if (cap) rdata <= ext;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: table-driven checks of lsu with a done-time scoreboard,
// plus hand sequences for busy-start, timeout and mid-transaction reset.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start_t, is_store;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, mem_rdata;
    logic        mem_gnt, mem_rvalid, gnt_t, rvalid_t;
    logic        busy, done, mem_req, mem_we;
    logic [1:0]  err;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        t_busy, t_done, t_mem_req, t_mem_we;
    logic [1:0]  t_err;
    logic [31:0] t_rdata, t_mem_addr, t_mem_wdata;
    logic [3:0]  t_mem_be;

    always #5 clk = ~clk;

    lsu dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
        .funct3(funct3), .addr(addr), .wdata(wdata), .busy(busy),
        .done(done), .err(err), .rdata(rdata), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    lsu #(.TIMEOUT(4)) dut_t (
        .clk(clk), .rst_n(rst_n), .start(start_t), .is_store(is_store),
        .funct3(funct3), .addr(addr), .wdata(wdata), .busy(t_busy),
        .done(t_done), .err(t_err), .rdata(t_rdata), .mem_req(t_mem_req),
        .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_be(t_mem_be),
        .mem_wdata(t_mem_wdata), .mem_gnt(gnt_t),
        .mem_rvalid(rvalid_t), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a, wd, mrd;
        int          gd, rd;
        logic [1:0]  e;
        logic [31:0] rexp;
        logic [3:0]  be;
        logic [31:0] mwd;
    } vec_t;

    typedef struct {
        logic [1:0]  e;
        logic [31:0] r;
        int          lat;
    } exp_t;

    exp_t        sbq[$];
    vec_t        tbl[16];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rdata = 32'd0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic [2:0] f3,
        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mrd,
        input int gd, input int rd, input logic [1:0] e,
        input logic [31:0] rexp, input logic [3:0] be,
        input logic [31:0] mwd);
        vec_t v;
        v = '{st, f3, a, wd, mrd, gd, rd, e, rexp, be, mwd};
        return v;
    endfunction

    task automatic run(input vec_t v);
        exp_t        x, got;
        logic [31:0] ma;
        int          k, nreq, nwait;
        bit          seen_req, fin;
        ma    = {v.a[31:2], 2'b00};
        x.e   = v.e;
        x.r   = (!v.st && v.e == 2'b00) ? v.rexp : last_rdata;
        x.lat = (v.e != 2'b00) ? 1 : (v.st ? 2 + v.gd : 3 + v.gd + v.rd);
        @(negedge clk);
        is_store  = v.st;
        funct3    = v.f3;
        addr      = v.a;
        wdata     = v.wd;
        mem_rdata = v.mrd;
        start     = 1'b1;
        sbq.push_back(x);
        @(negedge clk);
        start    = 1'b0;
        k        = 1;
        fin      = 1'b0;
        nreq     = 0;
        nwait    = 0;
        seen_req = 1'b0;
        while (!fin && k < 64) begin
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (done) begin
                got = sbq.pop_front();
                chk("latency", k, got.lat);
                chk("err", {30'd0, err}, {30'd0, got.e});
                chk("rdata", rdata, got.r);
                last_rdata = got.r;
                fin = 1'b1;
            end else if (mem_req) begin
                if (!seen_req) begin
                    chk("mem_addr", mem_addr, ma);
                    chk("mem_be", {28'd0, mem_be}, {28'd0, v.be});
                    chk("mem_we", {31'd0, mem_we}, {31'd0, v.st});
                    if (v.st) chk("mem_wdata", mem_wdata, v.mwd);
                end
                seen_req = 1'b1;
                mem_gnt  = (nreq == v.gd);
                nreq++;
            end else if (busy) begin
                mem_rvalid = (nwait == v.rd);
                nwait++;
            end
            @(negedge clk);
            k++;
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done");
            if (sbq.size() > 0) void'(sbq.pop_front());
        end
        if (v.e != 2'b00) chk("no_bus_on_err", {31'd0, seen_req}, 32'd0);
        chk("idle_after_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, nreq;
        rst_n      = 1'b0;
        start      = 1'b0;
        start_t    = 1'b0;
        is_store   = 1'b0;
        funct3     = 3'd0;
        addr       = 32'd0;
        wdata      = 32'd0;
        mem_rdata  = 32'd0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        gnt_t      = 1'b0;
        rvalid_t   = 1'b0;

        tbl[0]  = mk(1, 3'b010, 32'h1000, 32'hCAFEBABE, 0, 0, 0, 2'b00, 0, 4'b1111, 32'hCAFEBABE);
        tbl[1]  = mk(1, 3'b000, 32'h1003, 32'h000000A5, 0, 0, 0, 2'b00, 0, 4'b1000, 32'hA5A5A5A5);
        tbl[2]  = mk(1, 3'b001, 32'h1002, 32'h1234BEEF, 0, 2, 0, 2'b00, 0, 4'b1100, 32'hBEEFBEEF);
        tbl[3]  = mk(0, 3'b000, 32'h2002, 0, 32'h12F03456, 0, 3, 2'b00, 32'hFFFFFFF0, 4'b0100, 0);
        tbl[4]  = mk(0, 3'b100, 32'h2002, 0, 32'h12F03456, 0, 3, 2'b00, 32'h000000F0, 4'b0100, 0);
        tbl[5]  = mk(0, 3'b001, 32'h2002, 0, 32'h80017FFF, 1, 0, 2'b00, 32'hFFFF8001, 4'b1100, 0);
        tbl[6]  = mk(0, 3'b101, 32'h2002, 0, 32'h80017FFF, 1, 1, 2'b00, 32'h00008001, 4'b1100, 0);
        tbl[7]  = mk(0, 3'b010, 32'h2004, 0, 32'hDEADBEEF, 0, 0, 2'b00, 32'hDEADBEEF, 4'b1111, 0);
        tbl[8]  = mk(0, 3'b000, 32'h2000, 0, 32'h0000007F, 0, 0, 2'b00, 32'h0000007F, 4'b0001, 0);
        tbl[9]  = mk(0, 3'b001, 32'h3001, 0, 0, 0, 0, 2'b01, 0, 0, 0);
        tbl[10] = mk(0, 3'b011, 32'h3000, 0, 0, 0, 0, 2'b10, 0, 0, 0);
        tbl[11] = mk(1, 3'b100, 32'h3000, 0, 0, 0, 0, 2'b10, 0, 0, 0);
        tbl[12] = mk(0, 3'b011, 32'h3003, 0, 0, 0, 0, 2'b10, 0, 0, 0);
        tbl[13] = mk(0, 3'b010, 32'h3002, 0, 0, 0, 0, 2'b01, 0, 0, 0);
        tbl[14] = mk(1, 3'b001, 32'h3003, 0, 0, 0, 0, 2'b01, 0, 0, 0);
        tbl[15] = mk(0, 3'b110, 32'h3000, 0, 0, 0, 0, 2'b10, 0, 0, 0);

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {30'd0, err}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_bus", {mem_req, mem_we, mem_be}, 32'd0);
        chk("rst_maddr", mem_addr, 32'd0);
        chk("rst_mwdata", mem_wdata, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) run(tbl[i]);

        // start pulsed while busy must be dropped, not queued
        @(negedge clk);
        is_store = 1'b1;
        funct3   = 3'b010;
        addr     = 32'h1000;
        wdata    = 32'h11223344;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k     = 1;
        while (!done && k < 32) begin
            mem_gnt = 1'b0;
            start   = (k == 2);
            if (k == 2) begin
                addr     = 32'h5000;
                is_store = 1'b0;
            end
            if (mem_req) begin
                chk("busy_start_addr", mem_addr, 32'h1000);
                mem_gnt = (k == 4);
            end
            @(negedge clk);
            k++;
        end
        start   = 1'b0;
        mem_gnt = 1'b0;
        chk("busy_start_lat", k, 5);
        @(negedge clk);
        chk("busy_start_dropped", {30'd0, busy, done}, 32'd0);
        @(negedge clk);
        chk("busy_start_idle", {31'd0, busy}, 32'd0);

        // timeout instance: one good load, then one with no grant
        is_store  = 1'b0;
        funct3    = 3'b010;
        addr      = 32'h4000;
        mem_rdata = 32'h55AA1234;
        start_t   = 1'b1;
        @(negedge clk);
        start_t = 1'b0;
        gnt_t   = 1'b1;
        @(negedge clk);
        gnt_t    = 1'b0;
        rvalid_t = 1'b1;
        @(negedge clk);
        rvalid_t = 1'b0;
        chk("t_load_done", {31'd0, t_done}, 32'd1);
        chk("t_load_rdata", t_rdata, 32'h55AA1234);
        @(negedge clk);
        addr      = 32'h4008;
        mem_rdata = 32'hFFFFFFFF;
        start_t   = 1'b1;
        @(negedge clk);
        start_t = 1'b0;
        k       = 0;
        nreq    = 0;
        while (!t_done && k < 32) begin
            if (t_mem_req) nreq++;
            @(negedge clk);
            k++;
        end
        chk("tmo_req_cycles", nreq, 4);
        chk("tmo_done", {31'd0, t_done}, 32'd1);
        chk("tmo_err", {30'd0, t_err}, 32'd3);
        chk("tmo_rdata_kept", t_rdata, 32'h55AA1234);
        @(negedge clk);

        // asynchronous reset while waiting for read data
        is_store = 1'b0;
        funct3   = 3'b010;
        addr     = 32'h6000;
        start    = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("wait_state", {30'd0, busy, mem_req}, 32'd2);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {30'd0, busy, done}, 32'd0);
        chk("arst_err", {30'd0, err}, 32'd0);
        chk("arst_rdata", rdata, 32'd0);
        chk("arst_bus", {mem_req, mem_we, mem_be}, 32'd0);
        chk("arst_maddr", mem_addr, 32'd0);
        chk("arst_mwdata", mem_wdata, 32'd0);
        last_rdata = 32'd0;
        @(negedge clk);
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("stale_rvalid", {30'd0, busy, done}, 32'd0);
        chk("stale_rdata", rdata, 32'd0);
        run(tbl[0]);
        run(tbl[7]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
